// File: rtl/cpu_pkg.sv
// Shared constants for the multi-cycle controller: opcodes, ALU/PC select codes,
// FSM state encodings and instruction classes.
package cpu_pkg;

    localparam logic [3:0] OpAdd  = 4'h0;
    localparam logic [3:0] OpSub  = 4'h1;
    localparam logic [3:0] OpAnd  = 4'h2;
    localparam logic [3:0] OpOr   = 4'h3;
    localparam logic [3:0] OpSlt  = 4'h4;
    localparam logic [3:0] OpAddi = 4'h5;
    localparam logic [3:0] OpLw   = 4'h6;
    localparam logic [3:0] OpSw   = 4'h7;
    localparam logic [3:0] OpBeq  = 4'h8;
    localparam logic [3:0] OpBne  = 4'h9;
    localparam logic [3:0] OpJal  = 4'hA;
    localparam logic [3:0] OpJr   = 4'hB;
    localparam logic [3:0] OpHalt = 4'hF;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluSlt = 3'b100;

    localparam logic [1:0] PcPlus2 = 2'b00;
    localparam logic [1:0] PcImm   = 2'b01;
    localparam logic [1:0] PcAlu   = 2'b10;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        ClsRtype,
        ClsAddi,
        ClsLw,
        ClsSw,
        ClsBeq,
        ClsBne,
        ClsJal,
        ClsJr,
        ClsHalt,
        ClsIllegal
    } op_class_e;

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Controller <-> datapath bundle: opcode/status in, control strobes and debug out.
interface multi_cycle_ctrl_if;

    logic [3:0] op;
    logic       zero;
    logic       mem_ready;

    logic       pc_write;
    logic       ir_write;
    logic       wreg;
    logic       wmem;
    logic       memc;
    logic       m2reg;
    logic       alucsrc;
    logic       jal;
    logic [2:0] ALUOp;
    logic [1:0] PCsrc;
    logic [2:0] state;
    logic       halted;
    logic       illegal;
    logic       mem_err;

    // Datapath side.
    modport master (
        output op, zero, mem_ready,
        input  pc_write, ir_write, wreg, wmem, memc, m2reg, alucsrc, jal,
        input  ALUOp, PCsrc, state, halted, illegal, mem_err
    );

    // Controller side.
    modport slave (
        input  op, zero, mem_ready,
        output pc_write, ir_write, wreg, wmem, memc, m2reg, alucsrc, jal,
        output ALUOp, PCsrc, state, halted, illegal, mem_err
    );

endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: instruction class plus the ALU function it needs.
module ctrl_decode
    import cpu_pkg::*;
(
    input  logic [3:0] op_i,
    output op_class_e  cls_o,
    output logic [2:0] alu_op_o
);

    always_comb begin
        cls_o    = ClsIllegal;
        alu_op_o = AluAdd;
        case (op_i)
            OpAdd:  begin cls_o = ClsRtype; alu_op_o = AluAdd; end
            OpSub:  begin cls_o = ClsRtype; alu_op_o = AluSub; end
            OpAnd:  begin cls_o = ClsRtype; alu_op_o = AluAnd; end
            OpOr:   begin cls_o = ClsRtype; alu_op_o = AluOr;  end
            OpSlt:  begin cls_o = ClsRtype; alu_op_o = AluSlt; end
            OpAddi: cls_o = ClsAddi;
            OpLw:   cls_o = ClsLw;
            OpSw:   cls_o = ClsSw;
            OpBeq:  begin cls_o = ClsBeq; alu_op_o = AluSub; end
            OpBne:  begin cls_o = ClsBne; alu_op_o = AluSub; end
            OpJal:  cls_o = ClsJal;
            OpJr:   cls_o = ClsJr;
            OpHalt: cls_o = ClsHalt;
            default: cls_o = ClsIllegal;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, bounds memory
// waits with a timeout, and drives datapath controls from the latched opcode.
module multi_cycle_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              RESET,
    multi_cycle_ctrl_if.slave bus
);

    localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);

    state_e          state_q;
    logic [3:0]      op_q;
    logic [CntW-1:0] cnt_q;

    op_class_e  in_cls;
    op_class_e  q_cls;
    logic [2:0] in_alu;
    logic [2:0] q_alu;
    logic       timeout_hit;

    // DECODE looks at the live opcode; later states use the latched copy.
    ctrl_decode u_decode_in (
        .op_i     (bus.op),
        .cls_o    (in_cls),
        .alu_op_o (in_alu)
    );

    ctrl_decode u_decode_q (
        .op_i     (op_q),
        .cls_o    (q_cls),
        .alu_op_o (q_alu)
    );

    assign timeout_hit = !bus.mem_ready && (cnt_q == CntW'(MEM_TIMEOUT - 1));

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= StFetch;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StFetch: state_q <= StDecode;
                StDecode: begin
                    op_q <= bus.op;
                    if (in_cls == ClsHalt) begin
                        state_q <= StHalt;
                    end else if (in_cls == ClsIllegal) begin
                        state_q <= StFetch;
                    end else begin
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    case (q_cls)
                        ClsRtype, ClsAddi: state_q <= StWb;
                        ClsLw, ClsSw:      state_q <= StMem;
                        default:           state_q <= StFetch;
                    endcase
                end
                StMem: begin
                    if (bus.mem_ready) begin
                        cnt_q   <= '0;
                        state_q <= (q_cls == ClsLw) ? StWb : StFetch;
                    end else if (timeout_hit) begin
                        cnt_q   <= '0;
                        state_q <= StFetch;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StWb:   state_q <= StFetch;
                StHalt: state_q <= StHalt;
                default: state_q <= StFetch;
            endcase
        end
    end

    // Controls are gated by RESET so nothing is written on a reset cycle.
    always_comb begin
        bus.ir_write = 1'b0;
        bus.pc_write = 1'b0;
        bus.wreg     = 1'b0;
        bus.wmem     = 1'b0;
        bus.memc     = 1'b0;
        bus.m2reg    = 1'b0;
        bus.alucsrc  = 1'b0;
        bus.jal      = 1'b0;
        bus.ALUOp    = AluAdd;
        bus.PCsrc    = PcPlus2;
        bus.halted   = 1'b0;
        bus.illegal  = 1'b0;
        bus.mem_err  = 1'b0;
        if (RESET) begin
            unique case (state_q)
                StFetch: bus.ir_write = 1'b1;
                StDecode: begin
                    if (in_cls == ClsIllegal) begin
                        bus.illegal  = 1'b1;
                        bus.pc_write = 1'b1;
                    end
                end
                StExec: begin
                    bus.ALUOp = q_alu;
                    case (q_cls)
                        ClsAddi, ClsLw, ClsSw: bus.alucsrc = 1'b1;
                        ClsBeq: begin
                            bus.pc_write = 1'b1;
                            if (bus.zero) bus.PCsrc = PcImm;
                        end
                        ClsBne: begin
                            bus.pc_write = 1'b1;
                            if (!bus.zero) bus.PCsrc = PcImm;
                        end
                        ClsJal: begin
                            bus.jal      = 1'b1;
                            bus.wreg     = 1'b1;
                            bus.pc_write = 1'b1;
                            bus.PCsrc    = PcImm;
                        end
                        ClsJr: begin
                            bus.pc_write = 1'b1;
                            bus.PCsrc    = PcAlu;
                        end
                        default: ;
                    endcase
                end
                StMem: begin
                    bus.ALUOp   = q_alu;
                    bus.alucsrc = 1'b1;
                    bus.memc    = 1'b1;
                    bus.wmem    = (q_cls == ClsSw);
                    if (bus.mem_ready) begin
                        bus.pc_write = (q_cls == ClsSw);
                    end else if (timeout_hit) begin
                        bus.mem_err  = 1'b1;
                        bus.wmem     = 1'b0;
                        bus.pc_write = 1'b1;
                    end
                end
                StWb: begin
                    bus.ALUOp    = q_alu;
                    bus.wreg     = 1'b1;
                    bus.pc_write = 1'b1;
                    bus.m2reg    = (q_cls == ClsLw);
                    bus.alucsrc  = (q_cls == ClsAddi) || (q_cls == ClsLw);
                end
                StHalt: bus.halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.state = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: per-cycle expected control vectors per instruction.
module tb_multi_cycle_ctrl;

    logic CLK = 1'b0;
    logic RESET;
    int   total = 0;
    int   bad = 0;

    multi_cycle_ctrl_if bus ();

    multi_cycle_ctrl #(.MEM_TIMEOUT(15)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // {state, ir_write, pc_write, wreg, wmem, memc, m2reg, alucsrc, jal, ALUOp, PCsrc,
    //  halted, illegal, mem_err}
    logic [18:0] obs;
    assign obs = {bus.state, bus.ir_write, bus.pc_write, bus.wreg, bus.wmem, bus.memc,
                  bus.m2reg, bus.alucsrc, bus.jal, bus.ALUOp, bus.PCsrc,
                  bus.halted, bus.illegal, bus.mem_err};

    function automatic logic [18:0] ev(input logic [2:0] st, input logic [7:0] en,
                                       input logic [2:0] alu, input logic [1:0] pcs,
                                       input logic [2:0] fl);
        return {st, en, alu, pcs, fl};
    endfunction

    task automatic test_reset();
        RESET = 1'b0;
        repeat (2) @(posedge CLK);
        #2;
        total++;
        if (obs !== ev(3'd0, 8'b0000_0000, 3'd0, 2'd0, 3'd0)) begin
            bad++;
            $display("FAIL reset_hold got=%h want=%h", obs, ev(3'd0, 8'h00, 3'd0, 2'd0, 3'd0));
        end
        RESET = 1'b1;
        #1;
        total++;
        if (obs !== ev(3'd0, 8'b1000_0000, 3'd0, 2'd0, 3'd0)) begin
            bad++;
            $display("FAIL reset_fetch got=%h want=%h", obs, ev(3'd0, 8'h80, 3'd0, 2'd0, 3'd0));
        end
    endtask

    task automatic test_add();
        logic [18:0] e [4];
        e[0] = ev(3'd0, 8'b1000_0000, 3'd0, 2'd0, 3'd0);
        e[1] = ev(3'd1, 8'b0000_0000, 3'd0, 2'd0, 3'd0);
        e[2] = ev(3'd2, 8'b0000_0000, 3'd0, 2'd0, 3'd0);
        e[3] = ev(3'd4, 8'b0110_0000, 3'd0, 2'd0, 3'd0);
        bus.op = 4'h0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (obs !== e[i]) begin
                bad++;
                $display("FAIL add cyc%0d got=%h want=%h", i, obs, e[i]);
            end
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic test_alu();
        logic [18:0] e [8];
        logic [3:0]  o [8];
        e[0] = ev(3'd0, 8'b1000_0000, 3'd0, 2'd0, 3'd0);
        e[1] = ev(3'd1, 8'b0000_0000, 3'd0, 2'd0, 3'd0);
        e[2] = ev(3'd2, 8'b0000_0000, 3'd4, 2'd0, 3'd0);
        e[3] = ev(3'd4, 8'b0110_0000, 3'd4, 2'd0, 3'd0);
        e[4] = ev(3'd0, 8'b1000_0000, 3'd0, 2'd0, 3'd0);
        e[5] = ev(3'd1, 8'b0000_0000, 3'd0, 2'd0, 3'd0);
        e[6] = ev(3'd2, 8'b0000_0010, 3'd0, 2'd0, 3'd0);
        e[7] = ev(3'd4, 8'b0110_0010, 3'd0, 2'd0, 3'd0);
        for (int i = 0; i < 8; i++) o[i] = (i < 4) ? 4'h4 : 4'h5;
        for (int i = 0; i < 8; i++) begin
            bus.op = o[i];
            #1;
            total++;
            if (obs !== e[i]) begin
                bad++;
                $display("FAIL slt_addi cyc%0d got=%h want=%h", i, obs, e[i]);
            end
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic test_lw();
        logic [18:0] e [8];
        logic        mr [8];
        e[0] = ev(3'd0, 8'b1000_0000, 3'd0, 2'd0, 3'd0);
        e[1] = ev(3'd1, 8'b0000_0000, 3'd0, 2'd0, 3'd0);
        e[2] = ev(3'd2, 8'b0000_0010, 3'd0, 2'd0, 3'd0);
        for (int i = 3; i < 7; i++) e[i] = ev(3'd3, 8'b0000_1010, 3'd0, 2'd0, 3'd0);
        e[7] = ev(3'd4, 8'b0110_0110, 3'd0, 2'd0, 3'd0);
        for (int i = 0; i < 8; i++) mr[i] = (i == 6);
        bus.op = 4'h6;
        for (int i = 0; i < 8; i++) begin
            bus.mem_ready = mr[i];
            #1;
            total++;
            if (obs !== e[i]) begin
                bad++;
                $display("FAIL lw cyc%0d got=%h want=%h", i, obs, e[i]);
            end
            @(posedge CLK);
            #2;
        end
        bus.mem_ready = 1'b0;
    endtask

    task automatic test_branch();
        logic [18:0] e [12];
        logic [3:0]  o [4];
        logic        z [4];
        logic [1:0]  pcs [4];
        o[0] = 4'h8; z[0] = 1'b1; pcs[0] = 2'b01;
        o[1] = 4'h9; z[1] = 1'b1; pcs[1] = 2'b00;
        o[2] = 4'h8; z[2] = 1'b0; pcs[2] = 2'b00;
        o[3] = 4'h9; z[3] = 1'b0; pcs[3] = 2'b01;
        for (int k = 0; k < 4; k++) begin
            e[3*k]   = ev(3'd0, 8'b1000_0000, 3'd0, 2'd0, 3'd0);
            e[3*k+1] = ev(3'd1, 8'b0000_0000, 3'd0, 2'd0, 3'd0);
            e[3*k+2] = ev(3'd2, 8'b0100_0000, 3'd1, pcs[k], 3'd0);
        end
        for (int i = 0; i < 12; i++) begin
            bus.op = o[i/3];
            bus.zero = z[i/3];
            #1;
            total++;
            if (obs !== e[i]) begin
                bad++;
                $display("FAIL branch cyc%0d got=%h want=%h", i, obs, e[i]);
            end
            @(posedge CLK);
            #2;
        end
        bus.zero = 1'b0;
    endtask

    task automatic test_jal_jr();
        logic [18:0] e [6];
        e[0] = ev(3'd0, 8'b1000_0000, 3'd0, 2'd0, 3'd0);
        e[1] = ev(3'd1, 8'b0000_0000, 3'd0, 2'd0, 3'd0);
        e[2] = ev(3'd2, 8'b0110_0001, 3'd0, 2'b01, 3'd0);
        e[3] = ev(3'd0, 8'b1000_0000, 3'd0, 2'd0, 3'd0);
        e[4] = ev(3'd1, 8'b0000_0000, 3'd0, 2'd0, 3'd0);
        e[5] = ev(3'd2, 8'b0100_0000, 3'd0, 2'b10, 3'd0);
        for (int i = 0; i < 6; i++) begin
            bus.op = (i < 3) ? 4'hA : 4'hB;
            #1;
            total++;
            if (obs !== e[i]) begin
                bad++;
                $display("FAIL jal_jr cyc%0d got=%h want=%h", i, obs, e[i]);
            end
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic test_sw();
        logic [18:0] e [4];
        e[0] = ev(3'd0, 8'b1000_0000, 3'd0, 2'd0, 3'd0);
        e[1] = ev(3'd1, 8'b0000_0000, 3'd0, 2'd0, 3'd0);
        e[2] = ev(3'd2, 8'b0000_0010, 3'd0, 2'd0, 3'd0);
        e[3] = ev(3'd3, 8'b0101_1010, 3'd0, 2'd0, 3'd0);
        bus.op = 4'h7;
        for (int i = 0; i < 4; i++) begin
            bus.mem_ready = (i == 3);
            #1;
            total++;
            if (obs !== e[i]) begin
                bad++;
                $display("FAIL sw cyc%0d got=%h want=%h", i, obs, e[i]);
            end
            @(posedge CLK);
            #2;
        end
        bus.mem_ready = 1'b0;
    endtask

    task automatic test_sw_timeout();
        logic [18:0] e [18];
        e[0] = ev(3'd0, 8'b1000_0000, 3'd0, 2'd0, 3'd0);
        e[1] = ev(3'd1, 8'b0000_0000, 3'd0, 2'd0, 3'd0);
        e[2] = ev(3'd2, 8'b0000_0010, 3'd0, 2'd0, 3'd0);
        for (int i = 3; i < 17; i++) e[i] = ev(3'd3, 8'b0001_1010, 3'd0, 2'd0, 3'd0);
        e[17] = ev(3'd3, 8'b0100_1010, 3'd0, 2'd0, 3'b001);
        bus.op = 4'h7;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            #1;
            total++;
            if (obs !== e[i]) begin
                bad++;
                $display("FAIL sw_timeout cyc%0d got=%h want=%h", i, obs, e[i]);
            end
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic test_reset_in_mem();
        logic [18:0] e [5];
        e[0] = ev(3'd0, 8'b1000_0000, 3'd0, 2'd0, 3'd0);
        e[1] = ev(3'd1, 8'b0000_0000, 3'd0, 2'd0, 3'd0);
        e[2] = ev(3'd2, 8'b0000_0010, 3'd0, 2'd0, 3'd0);
        e[3] = ev(3'd3, 8'b0001_1010, 3'd0, 2'd0, 3'd0);
        e[4] = ev(3'd3, 8'b0001_1010, 3'd0, 2'd0, 3'd0);
        bus.op = 4'h7;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (obs !== e[i]) begin
                bad++;
                $display("FAIL mem_reset cyc%0d got=%h want=%h", i, obs, e[i]);
            end
            @(posedge CLK);
            #2;
        end
        RESET = 1'b0;
        #1;
        total++;
        if (obs !== ev(3'd3, 8'b0000_0000, 3'd0, 2'd0, 3'd0)) begin
            bad++;
            $display("FAIL mem_reset_edge got=%h want=%h", obs, ev(3'd3, 8'h00, 3'd0, 2'd0, 3'd0));
        end
        @(posedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        total++;
        if (obs !== ev(3'd0, 8'b1000_0000, 3'd0, 2'd0, 3'd0)) begin
            bad++;
            $display("FAIL mem_reset_after got=%h want=%h", obs, ev(3'd0, 8'h80, 3'd0, 2'd0, 3'd0));
        end
    endtask

    task automatic test_illegal_halt();
        logic [18:0] e [24];
        e[0] = ev(3'd0, 8'b1000_0000, 3'd0, 2'd0, 3'd0);
        e[1] = ev(3'd1, 8'b0100_0000, 3'd0, 2'd0, 3'b010);
        e[2] = ev(3'd0, 8'b1000_0000, 3'd0, 2'd0, 3'd0);
        e[3] = ev(3'd1, 8'b0000_0000, 3'd0, 2'd0, 3'd0);
        for (int i = 4; i < 24; i++) e[i] = ev(3'd5, 8'b0000_0000, 3'd0, 2'd0, 3'b100);
        for (int i = 0; i < 24; i++) begin
            bus.op = (i < 2) ? 4'hD : 4'hF;
            #1;
            total++;
            if (obs !== e[i]) begin
                bad++;
                $display("FAIL illegal_halt cyc%0d got=%h want=%h", i, obs, e[i]);
            end
            @(posedge CLK);
            #2;
        end
        RESET = 1'b0;
        #1;
        total++;
        if (obs !== ev(3'd5, 8'b0000_0000, 3'd0, 2'd0, 3'd0)) begin
            bad++;
            $display("FAIL halt_reset got=%h want=%h", obs, ev(3'd5, 8'h00, 3'd0, 2'd0, 3'd0));
        end
        @(posedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        total++;
        if (obs !== ev(3'd0, 8'b1000_0000, 3'd0, 2'd0, 3'd0)) begin
            bad++;
            $display("FAIL halt_exit got=%h want=%h", obs, ev(3'd0, 8'h80, 3'd0, 2'd0, 3'd0));
        end
    endtask

    initial begin
        RESET = 1'b0;
        bus.op = 4'h0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;
        test_reset();
        test_add();
        test_alu();
        test_lw();
        test_branch();
        test_jal_jr();
        test_sw();
        test_sw_timeout();
        test_reset_in_mem();
        test_illegal_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, meaning the maximum number of MEM-state cycles spent waiting for mem_ready.
REQ-002 SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RESET, input, 1, reset: synchronous, active-low.
REQ-004 SHALL have port op, input, 4, the instruction opcode; valid from DECODE onward.
REQ-005 SHALL have port zero, input, 1, the ALU zero flag; sampled only in EXEC.
REQ-006 SHALL have port mem_ready, input, 1, data-memory access complete.
REQ-007 SHALL have ports pc_write and ir_write, output, 1 each, PC load enable and IR load enable.
REQ-008 SHALL have ports wreg, wmem, memc, m2reg, alucsrc and jal, output, 1 each, datapath controls with the existing meanings.
REQ-009 SHALL have port ALUOp, output, 3, ALU function: 000 add, 001 sub, 010 and, 011 or, 100 slt.
REQ-010 SHALL have port PCsrc, output, 2, next-PC select: 00 PC+2, 01 PC+imm, 10 ALU result.
REQ-011 SHALL have port state, output, 3, current FSM state, for debug.
REQ-012 SHALL have ports halted, illegal and mem_err, output, 1 each: halted is a level; illegal and mem_err are one-cycle pulses.

Function
REQ-013 SHALL decode opcodes as follows:
- 0-4: R-type; ALUOp = op[2:0].
- 5: ADDI.
- 6: LW.
- 7: SW.
- 8: BEQ.
- 9: BNE.
- A: JAL.
- B: JR.
- F: HALT.
- C, D, E: illegal.
REQ-014 SHALL implement the states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and HALT=5.
REQ-015 SHALL, in FETCH, assert ir_write only, then go to DECODE.
REQ-016 SHALL, in DECODE, register op into op_q, then:
- HALT: go to HALT.
- illegal: pulse illegal, assert pc_write with PCsrc=00, go to FETCH.
- otherwise: go to EXEC.
REQ-017 SHALL drive EXEC outputs from op_q; ALUOp is valid throughout EXEC, MEM and WB.
REQ-018 SHALL handle R-type and ADDI as EXEC then WB; ADDI sets alucsrc=1. In WB: wreg=1, m2reg=0, pc_write=1, PCsrc=00.
REQ-019 SHALL handle LW as EXEC then MEM then WB. EXEC and MEM drive ALUOp=000, alucsrc=1. MEM holds memc=1. WB: wreg=1, m2reg=1, pc_write=1, PCsrc=00.
REQ-020 SHALL handle SW as EXEC then MEM. MEM holds wmem=1 and memc=1. On mem_ready: pc_write=1, PCsrc=00, go to FETCH.
REQ-021 SHALL stay in MEM while mem_ready=0, holding all MEM controls stable.
REQ-022 SHALL, if mem_ready stays 0 for MEM_TIMEOUT cycles, pulse mem_err, deassert wreg and wmem, assert pc_write with PCsrc=00, and go to FETCH.
REQ-023 SHALL handle BEQ and BNE in EXEC only: ALUOp=001, pc_write=1, then FETCH.
- PCsrc=01 when taken: zero=1 for BEQ, zero=0 for BNE.
- PCsrc=00 otherwise.
REQ-024 SHALL handle JAL in EXEC only: jal=1, wreg=1, pc_write=1, PCsrc=01, then FETCH.
REQ-025 SHALL handle JR in EXEC only: ALUOp=000, alucsrc=0, pc_write=1, PCsrc=10, then FETCH.
REQ-026 SHALL, in HALT, hold all enables at 0 and halted=1, leaving HALT only via reset.
REQ-027 SHALL assert each of pc_write, wreg and wmem for at most one cycle per instruction.
REQ-028 SHALL never assert wreg and wmem in the same cycle.
REQ-029 SHALL take exactly these cycles per instruction:
- R, ADDI: 4.
- LW: 5 + wait cycles.
- SW: 4 + wait cycles.
- BEQ, BNE, JAL, JR: 3.
- illegal: 2.

Reset
REQ-030 SHALL, while RESET=0 at a rising edge, go to FETCH with op_q=0 and the timeout counter at 0.
REQ-031 SHALL hold all enables at 0 and ALUOp=000, PCsrc=00, halted=0, illegal=0, mem_err=0 while RESET=0.
REQ-032 SHALL take reset from any state, including MEM mid-wait; no write may occur on the reset cycle.
REQ-033 SHALL leave reset with FETCH as the first active state.

Structure
REQ-034 SHALL take the opcode constants, ALUOp codes, PCsrc codes and state encodings from shared package cpu_pkg.
REQ-035 SHALL place the combinational opcode-to-class decoder in sub-module ctrl_decode; the FSM and timeout counter stay in multi_cycle_ctrl.

Verification
REQ-036 SHALL cover: ADD (op=0) -> states 0,1,2,4; wreg=1 and pc_write=1 with PCsrc=00 only in cycle 4; ALUOp=000.
REQ-037 SHALL cover: LW (op=6) with mem_ready low 3 cycles -> MEM lasts 4 cycles with memc=1 throughout, then WB with m2reg=1 and wreg=1; 8 cycles total.
REQ-038 SHALL cover: BEQ (op=8) with zero=1 -> PCsrc=01, pc_write=1 in EXEC; BNE (op=9) with zero=1 -> PCsrc=00.
REQ-039 SHALL cover: SW with mem_ready held 0 -> mem_err pulses after 15 MEM cycles, no wreg, return to FETCH.
REQ-040 SHALL cover: op=D -> illegal pulses in DECODE; op=F -> halted=1 and stays for 20 cycles; RESET=0 for 1 cycle -> state=0.
REQ-041 SHALL cover: RESET=0 asserted during MEM of SW -> wmem=0 on that edge, next state FETCH, no pc_write.
